// File: rtl/peri_bridge_pkg.sv
// Shared types and constants for the CPU-to-peripheral bridge: the address
// regions the bridge decodes and the helper that classifies a CPU address.
package peri_bridge_pkg;

`include "defines.vh"

  localparam logic [31:0] ADDR_DIG        = `PERI_ADDR_DIG;
  localparam logic [31:0] ADDR_LED        = `PERI_ADDR_LED;
  localparam logic [31:0] ADDR_SW         = `PERI_ADDR_SW;
  localparam logic [31:0] ADDR_BTN        = `PERI_ADDR_BTN;
  localparam logic [31:0] PERI_BASE       = `PERI_SPACE_BASE;
  localparam logic [31:0] DEB_MAX_DEFAULT = `PERI_DEB_MAX;

  localparam int NUM_BTN = 5;
  localparam int NUM_SW  = 24;

  typedef enum logic [2:0] {
    REG_DRAM,
    REG_DIG,
    REG_LED,
    REG_SW,
    REG_BTN,
    REG_UNMAPPED
  } region_e;

  // Exact-match decode of the four peripherals; anything else in the top
  // page is an unmapped peripheral, everything below it belongs to DRAM.
  function automatic region_e decode_region(input logic [31:0] addr);
    region_e r;
    if (addr == ADDR_DIG)       r = REG_DIG;
    else if (addr == ADDR_LED)  r = REG_LED;
    else if (addr == ADDR_SW)   r = REG_SW;
    else if (addr == ADDR_BTN)  r = REG_BTN;
    else if (addr >= PERI_BASE) r = REG_UNMAPPED;
    else                        r = REG_DRAM;
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One-bit button debouncer. The input must already be synchronised to clk_i.
// The debounced level only changes after the input has disagreed with it for
// DEB_MAX+1 consecutive cycles; any agreement restarts the window.
module btn_debounce
  import peri_bridge_pkg::*;
#(
  parameter logic [31:0] DEB_MAX = DEB_MAX_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic deb_o,
  output logic rise_o
);

  logic [31:0] cnt_q;
  logic        deb_q;
  logic        at_max;

  assign at_max = (cnt_q == DEB_MAX);
  assign deb_o  = deb_q;
  // High during the cycle whose edge will flip the debounced level to 1,
  // so a sticky press flag can be set on that same edge.
  assign rise_o = btn_i && !deb_q && at_max;

  // Count cycles of disagreement; flip the debounced level when the window fills.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else if (btn_i == deb_q) begin
      cnt_q <= '0;
    end else if (at_max) begin
      cnt_q <= '0;
      deb_q <= ~deb_q;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule

// File: rtl/defines.vh
// Board-level constants for the peripheral bridge: memory-mapped peripheral
// addresses and the debounce window used on the real board clock.
`ifndef PERI_DEFINES_VH
`define PERI_DEFINES_VH

`define PERI_ADDR_DIG   32'hFFFF_F000
`define PERI_ADDR_LED   32'hFFFF_F060
`define PERI_ADDR_SW    32'hFFFF_F070
`define PERI_ADDR_BTN   32'hFFFF_F078
`define PERI_SPACE_BASE 32'hFFFF_F000
`define PERI_DEB_MAX    32'd999_999

`endif

// File: rtl/peri_bridge.sv
// CPU data-bus bridge: routes stores to DRAM, the seven-segment display and
// the LED register, and returns loads from DRAM, switches, buttons and LEDs
// with one cycle of latency. Switches and buttons are synchronised, buttons
// are debounced and latch sticky press flags that clear when read.
module peri_bridge
  import peri_bridge_pkg::*;
#(
  parameter logic [31:0] DEB_MAX     = DEB_MAX_DEFAULT,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic        re_i,
  output logic [31:0] rdata_o,
  output logic        dram_we_o,
  input  logic [31:0] dram_rdata_i,
  output logic        dig_we_o,
  output logic [31:0] dig_addr_o,
  output logic [31:0] dig_data_o,
  output logic [23:0] led_o,
  input  logic [23:0] sw_i,
  input  logic [4:0]  btn_i
);

  region_e region;

  logic [SYNC_STAGES-1:0][NUM_SW-1:0]  sw_pipe_q;
  logic [SYNC_STAGES-1:0][NUM_BTN-1:0] btn_pipe_q;
  logic [NUM_SW-1:0]  sw_sync;
  logic [NUM_BTN-1:0] btn_sync;

  logic [NUM_BTN-1:0] btn_deb;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] press_flags;

  logic        load_btn;
  logic [31:0] peri_rdata;
  logic        rd_pend_q;
  logic        rd_dram_q;
  logic [31:0] rd_peri_q;
  logic [31:0] rd_hold_q;

  assign region = decode_region(addr_i);

  assign dram_we_o  = rst_ni && we_i && (region == REG_DRAM);
  assign dig_we_o   = rst_ni && we_i && (region == REG_DIG);
  assign dig_addr_o = addr_i;
  assign dig_data_o = wdata_i;

  assign sw_sync  = sw_pipe_q[SYNC_STAGES-1];
  assign btn_sync = btn_pipe_q[SYNC_STAGES-1];

  // Multi-flop synchronisers bring the asynchronous switches and buttons into clk_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_pipe_q  <= '0;
      btn_pipe_q <= '0;
    end else begin
      sw_pipe_q  <= {sw_pipe_q[SYNC_STAGES-2:0], sw_i};
      btn_pipe_q <= {btn_pipe_q[SYNC_STAGES-2:0], btn_i};
    end
  end

  for (genvar k = 0; k < NUM_BTN; k++) begin : g_deb
    btn_debounce #(
      .DEB_MAX(DEB_MAX)
    ) u_deb (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .btn_i (btn_sync[k]),
      .deb_o (btn_deb[k]),
      .rise_o(btn_rise[k])
    );
  end

  assign load_btn = re_i && (region == REG_BTN);

  // Sticky press flags: a BTN load clears them, but a press landing on the same edge survives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      press_flags <= '0;
    end else begin
      press_flags <= (load_btn ? '0 : press_flags) | btn_rise;
    end
  end

  // LED register is written only by an exact-address store.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      led_o <= '0;
    end else if (we_i && (region == REG_LED)) begin
      led_o <= wdata_i[23:0];
    end
  end

  // Peripheral read value selected by the current address, sampled on a load.
  always_comb begin
    peri_rdata = 32'h0;
    case (region)
      REG_SW:  peri_rdata = {8'h0, sw_sync};
      REG_BTN: peri_rdata = {19'h0, press_flags, 3'h0, btn_deb};
      REG_LED: peri_rdata = {8'h0, led_o};
      default: peri_rdata = 32'h0;
    endcase
  end

  // Register the load's source; after the data cycle, remember what was shown so rdata_o holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pend_q <= 1'b0;
      rd_dram_q <= 1'b0;
      rd_peri_q <= '0;
      rd_hold_q <= '0;
    end else begin
      rd_pend_q <= re_i;
      if (rd_pend_q) begin
        rd_hold_q <= rdata_o;
      end
      if (re_i) begin
        rd_dram_q <= (region == REG_DRAM);
        rd_peri_q <= peri_rdata;
      end
    end
  end

  assign rdata_o = !rd_pend_q ? rd_hold_q : (rd_dram_q ? dram_rdata_i : rd_peri_q);

endmodule

// File: tb/tb_peri_bridge.sv
// Self-checking bench for peri_bridge with a short debounce window.
module tb_peri_bridge;
  import peri_bridge_pkg::*;

  localparam int          SYNC = 2;
  localparam logic [31:0] DEB  = 32'd7;
  localparam int          RISE_EDGES = SYNC + int'(DEB) + 1;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        we_i = 1'b0;
  logic        re_i = 1'b0;
  logic [31:0] rdata_o;
  logic        dram_we_o;
  logic [31:0] dram_rdata_i = '0;
  logic        dig_we_o;
  logic [31:0] dig_addr_o;
  logic [31:0] dig_data_o;
  logic [23:0] led_o;
  logic [23:0] sw_i = '0;
  logic [4:0]  btn_i = '0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [23:0] m_led   = '0;
  logic [23:0] m_sw    = '0;
  logic [4:0]  m_flags = '0;
  logic [4:0]  m_deb   = '0;

  peri_bridge #(
    .DEB_MAX(DEB),
    .SYNC_STAGES(SYNC)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .we_i        (we_i),
    .re_i        (re_i),
    .rdata_o     (rdata_o),
    .dram_we_o   (dram_we_o),
    .dram_rdata_i(dram_rdata_i),
    .dig_we_o    (dig_we_o),
    .dig_addr_o  (dig_addr_o),
    .dig_data_o  (dig_data_o),
    .led_o       (led_o),
    .sw_i        (sw_i),
    .btn_i       (btn_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // Behavioural RAM: read data appears one cycle after the address.
  always @(posedge clk_i) dram_rdata_i <= mem_val(addr_i);

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (a == ADDR_SW)           return {8'h0, m_sw};
    else if (a == ADDR_BTN)     return {19'h0, m_flags, 3'h0, m_deb};
    else if (a == ADDR_LED)     return {8'h0, m_led};
    else if (a >= 32'hFFFF_F000) return 32'h0;
    else                         return mem_val(a);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    we_i = 1'b0;
    re_i = 1'b0;
  endtask

  task automatic test_reset();
    we_i = 1'b1; addr_i = ADDR_DIG; wdata_i = 32'hDEAD_BEEF;
    #2;
    n_tests++;
    if (dig_we_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dig_we: got %b, expected 0", dig_we_o); end
    addr_i = 32'h0000_0100; re_i = 1'b1;
    #1;
    n_tests++;
    if (dram_we_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dram_we: got %b, expected 0", dram_we_o); end
    addr_i = ADDR_LED;
    tick(); tick();
    n_tests++;
    if (led_o !== 24'h0) begin n_fail++; $display("[TB] FAIL reset_led: got %h, expected 0", led_o); end
    n_tests++;
    if (rdata_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h, expected 0", rdata_o); end
    n_tests++;
    if (u_dut.btn_deb !== 5'h0) begin n_fail++; $display("[TB] FAIL reset_btn_deb: got %h, expected 0", u_dut.btn_deb); end
    idle();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_dig_store();
    addr_i = ADDR_DIG; wdata_i = 32'h1234_5678; we_i = 1'b1;
    #1;
    n_tests++;
    if (dig_we_o !== 1'b1) begin n_fail++; $display("[TB] FAIL dig_we: got %b, expected 1", dig_we_o); end
    n_tests++;
    if (dig_data_o !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL dig_data: got %h, expected 12345678", dig_data_o); end
    n_tests++;
    if (dig_addr_o !== ADDR_DIG) begin n_fail++; $display("[TB] FAIL dig_addr: got %h, expected %h", dig_addr_o, ADDR_DIG); end
    n_tests++;
    if (dram_we_o !== 1'b0) begin n_fail++; $display("[TB] FAIL dig_dram_we: got %b, expected 0", dram_we_o); end
    tick();
    idle();
  endtask

  task automatic test_led();
    addr_i = ADDR_LED; wdata_i = 32'h00AB_CDEF; we_i = 1'b1;
    tick();
    m_led = 24'hAB_CDEF;
    n_tests++;
    if (led_o !== 24'hAB_CDEF) begin n_fail++; $display("[TB] FAIL led_store: got %h, expected abcdef", led_o); end
    we_i = 1'b0; re_i = 1'b1;
    tick();
    n_tests++;
    if (rdata_o !== 32'h00AB_CDEF) begin n_fail++; $display("[TB] FAIL led_load: got %h, expected 00abcdef", rdata_o); end
    re_i = 1'b0; addr_i = 32'h0000_0040;
    tick(); tick();
    n_tests++;
    if (rdata_o !== 32'h00AB_CDEF) begin n_fail++; $display("[TB] FAIL rdata_hold: got %h, expected 00abcdef", rdata_o); end
  endtask

  task automatic test_sw();
    sw_i = 24'hF0F0F0; m_sw = 24'hF0F0F0;
    for (int i = 0; i < SYNC + 1; i++) tick();
    addr_i = ADDR_SW; re_i = 1'b1;
    tick();
    idle();
    n_tests++;
    if (rdata_o !== 32'h00F0_F0F0) begin n_fail++; $display("[TB] FAIL sw_load: got %h, expected 00f0f0f0", rdata_o); end
  endtask

  task automatic test_random();
    logic [31:0] exp_rd;
    logic [31:0] exp_rd_next;
    logic [31:0] unmapped [3];
    unmapped[0] = 32'hFFFF_F004; unmapped[1] = 32'hFFFF_FFFC; unmapped[2] = 32'hFFFF_F100;
    sw_i = 24'($urandom); m_sw = sw_i;
    for (int i = 0; i < SYNC + 1; i++) tick();
    exp_rd = rdata_o;
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 5))
        0: addr_i = $urandom_range(0, 32'hFFFF_EFFF);
        1: addr_i = ADDR_DIG;
        2: addr_i = ADDR_LED;
        3: addr_i = ADDR_SW;
        4: addr_i = ADDR_BTN;
        default: addr_i = unmapped[$urandom_range(0, 2)];
      endcase
      we_i = 1'($urandom_range(0, 1));
      re_i = 1'($urandom_range(0, 1));
      wdata_i = $urandom;
      #1;
      n_tests++;
      if (dram_we_o !== (we_i && addr_i < 32'hFFFF_F000)) begin
        n_fail++; $display("[TB] FAIL rand_dram_we: addr %h got %b, expected %b", addr_i, dram_we_o, we_i && addr_i < 32'hFFFF_F000);
      end
      n_tests++;
      if (dig_we_o !== (we_i && addr_i == ADDR_DIG) || dig_data_o !== wdata_i) begin
        n_fail++; $display("[TB] FAIL rand_dig: addr %h got we %b data %h, expected we %b data %h", addr_i, dig_we_o, dig_data_o, we_i && addr_i == ADDR_DIG, wdata_i);
      end
      exp_rd_next = re_i ? ref_read(addr_i) : exp_rd;
      tick();
      if (we_i && addr_i == ADDR_LED) m_led = wdata_i[23:0];
      if (re_i && addr_i == ADDR_BTN) m_flags = '0;
      exp_rd = exp_rd_next;
      n_tests++;
      if (led_o !== m_led) begin n_fail++; $display("[TB] FAIL rand_led: got %h, expected %h", led_o, m_led); end
      n_tests++;
      if (rdata_o !== exp_rd) begin n_fail++; $display("[TB] FAIL rand_rdata: addr %h got %h, expected %h", addr_i, rdata_o, exp_rd); end
    end
    idle();
  endtask

  task automatic test_debounce();
    int first_rise;
    logic [31:0] exp_rd;
    for (int i = 0; i < 4; i++) begin
      btn_i[0] = 1'($urandom_range(0, 1));
      tick();
    end
    btn_i[0] = 1'b0;
    tick();
    btn_i[0] = 1'b1;
    first_rise = 0;
    for (int e = 1; e <= RISE_EDGES + 4; e++) begin
      tick();
      if (first_rise == 0 && u_dut.btn_deb[0] === 1'b1) first_rise = e;
    end
    n_tests++;
    if (first_rise != RISE_EDGES) begin n_fail++; $display("[TB] FAIL deb_rise_edge: got %0d, expected %0d", first_rise, RISE_EDGES); end
    m_deb[0] = 1'b1; m_flags[0] = 1'b1;
    addr_i = ADDR_BTN; re_i = 1'b1;
    exp_rd = ref_read(ADDR_BTN);
    tick();
    m_flags = '0;
    n_tests++;
    if (rdata_o !== exp_rd || exp_rd !== 32'h0000_0101) begin n_fail++; $display("[TB] FAIL btn_load1: got %h, expected %h", rdata_o, exp_rd); end
    exp_rd = ref_read(ADDR_BTN);
    tick();
    n_tests++;
    if (rdata_o !== exp_rd) begin n_fail++; $display("[TB] FAIL btn_load2: got %h, expected %h", rdata_o, exp_rd); end
    idle();
  endtask

  task automatic test_press_same_edge();
    logic [31:0] exp_rd;
    btn_i[2] = 1'b1;
    for (int e = 1; e < RISE_EDGES; e++) tick();
    addr_i = ADDR_BTN; re_i = 1'b1;
    exp_rd = ref_read(ADDR_BTN);
    tick();
    m_flags = 5'b00100; m_deb[2] = 1'b1;
    n_tests++;
    if (rdata_o !== exp_rd) begin n_fail++; $display("[TB] FAIL same_edge_load: got %h, expected %h", rdata_o, exp_rd); end
    exp_rd = ref_read(ADDR_BTN);
    tick();
    m_flags = '0;
    n_tests++;
    if (rdata_o !== exp_rd) begin n_fail++; $display("[TB] FAIL same_edge_next: got %h, expected %h", rdata_o, exp_rd); end
    exp_rd = ref_read(ADDR_BTN);
    tick();
    n_tests++;
    if (rdata_o !== exp_rd) begin n_fail++; $display("[TB] FAIL same_edge_cleared: got %h, expected %h", rdata_o, exp_rd); end
    idle();
  endtask

  task automatic test_async_reset_mid_debounce();
    int first_rise;
    logic [31:0] exp_rd;
    addr_i = ADDR_LED; wdata_i = 32'h00FF_FFFF; we_i = 1'b1;
    tick();
    we_i = 1'b0; re_i = 1'b1;
    tick();
    idle();
    n_tests++;
    if (rdata_o !== 32'h00FF_FFFF) begin n_fail++; $display("[TB] FAIL pre_reset_rdata: got %h, expected 00ffffff", rdata_o); end
    btn_i[1] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    #3;
    rst_ni = 1'b0;
    #1;
    m_led = '0; m_flags = '0; m_deb = '0;
    n_tests++;
    if (led_o !== 24'h0) begin n_fail++; $display("[TB] FAIL async_led: got %h, expected 0", led_o); end
    n_tests++;
    if (rdata_o !== 32'h0) begin n_fail++; $display("[TB] FAIL async_rdata: got %h, expected 0", rdata_o); end
    n_tests++;
    if (u_dut.btn_deb !== 5'h0) begin n_fail++; $display("[TB] FAIL async_btn_deb: got %h, expected 0", u_dut.btn_deb); end
    tick();
    rst_ni = 1'b1;
    first_rise = 0;
    for (int e = 1; e <= RISE_EDGES + 4; e++) begin
      tick();
      if (first_rise == 0 && u_dut.btn_deb !== 5'h0) begin
        first_rise = e;
        n_tests++;
        if (u_dut.btn_deb !== 5'b00111) begin n_fail++; $display("[TB] FAIL post_reset_deb: got %b, expected 00111", u_dut.btn_deb); end
      end
    end
    n_tests++;
    if (first_rise != RISE_EDGES) begin n_fail++; $display("[TB] FAIL post_reset_rise_edge: got %0d, expected %0d", first_rise, RISE_EDGES); end
    m_deb = 5'b00111; m_flags = 5'b00111;
    addr_i = ADDR_BTN; re_i = 1'b1;
    exp_rd = ref_read(ADDR_BTN);
    tick();
    idle();
    n_tests++;
    if (rdata_o !== exp_rd) begin n_fail++; $display("[TB] FAIL post_reset_btn_load: got %h, expected %h", rdata_o, exp_rd); end
  endtask

  initial begin
    test_reset();
    test_dig_store();
    test_led();
    test_sw();
    test_random();
    test_debounce();
    test_press_same_edge();
    test_async_reset_mid_debounce();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
